// File: rtl/par_stats_sink_pkg.sv
// par_stats_sink_pkg: shared widths and the hospitality LFSR step for the parallel-link sinks
package par_stats_sink_pkg;
  localparam int PAYLOAD_SIZE = 32;
  localparam int ADDR_BITS = 4;
  localparam int RX_W = 32;
  localparam int MIS_W = 16;
  localparam int LSUM_W = 40;
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction
endpackage

// File: rtl/sink_hosp_lfsr.sv
// sink_hosp_lfsr: pseudo-random hospitality source; busy_next is high when the LFSR exceeds SINK_HOSP
module sink_hosp_lfsr
  import par_stats_sink_pkg::*;
#(
  parameter int unsigned SINK_HOSP = 255,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic clk,
  input  logic reset,
  output logic busy_next
);
  localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [7:0] HOSP = SINK_HOSP[7:0];
  logic [7:0] lfsr;
  // Fibonacci LFSR advances every cycle; a zero seed would lock up so it is replaced
  always_ff @(posedge clk or posedge reset)
    if (reset) lfsr <= SEED;
    else lfsr <= lfsr_step(lfsr);
  assign busy_next = lfsr > HOSP;
endmodule

// File: rtl/par_stats_sink.sv
// par_stats_sink: router local-port sink that checks delivery and accumulates latency statistics
module par_stats_sink
  import par_stats_sink_pkg::*;
#(
  parameter logic [ADDR_BITS-1:0] ID = '0,
  parameter int unsigned SINK_HOSP = 255,
  parameter logic [7:0] LFSR_SEED = 8'hA5,
  parameter int TS_BITS = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic                           busy,
  input  logic [PAYLOAD_SIZE+ADDR_BITS-1:0] data,
  input  logic                           valid,
  input  logic                           stats_clear,
  output logic [RX_W-1:0]                rx_count,
  output logic [MIS_W-1:0]               misroute_count,
  output logic [LSUM_W-1:0]              latency_sum,
  output logic [TS_BITS-1:0]             latency_max,
  output logic                           overflow
);
  logic busy_next, xfer, v1, id_ok, rx_sat, mis_sat, unused_bits;
  logic [TS_BITS-1:0] ts, t1, lat;
  logic [PAYLOAD_SIZE+ADDR_BITS-1:0] d1;
  logic [LSUM_W:0] sum_ext;

  sink_hosp_lfsr #(.SINK_HOSP(SINK_HOSP), .LFSR_SEED(LFSR_SEED)) u_hosp (
    .clk(clk), .reset(reset), .busy_next(busy_next)
  );

  assign xfer = valid & ~busy;
  assign unused_bits = ^d1;

  // accounting terms for the packet sitting in stage 1; modular subtraction absorbs timebase wrap
  always_comb begin
    id_ok = d1[PAYLOAD_SIZE+ADDR_BITS-1:PAYLOAD_SIZE] == ID;
    lat = t1 - d1[TS_BITS-1:0];
    sum_ext = {1'b0, latency_sum} + (LSUM_W+1)'(lat);
    rx_sat = &rx_count;
    mis_sat = &misroute_count;
  end

  // busy is registered so the upstream sees a stable refusal for the whole cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) busy <= 1'b1;
    else busy <= busy_next;

  // free-running timebase used to time-stamp captures
  always_ff @(posedge clk or posedge reset)
    if (reset) ts <= '0;
    else ts <= ts + TS_BITS'(1);

  // stage 1: capture the packet and its arrival time on a transfer
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      v1 <= 1'b0;
      d1 <= '0;
      t1 <= '0;
    end else begin
      v1 <= xfer;
      if (xfer) begin
        d1 <= data;
        t1 <= ts;
      end
    end

  // stage 2: saturating statistics; a clear overrides the packet being accounted
  always_ff @(posedge clk or posedge reset)
    if (reset || stats_clear) begin
      rx_count <= '0;
      misroute_count <= '0;
      latency_sum <= '0;
      latency_max <= '0;
      overflow <= 1'b0;
    end else if (v1) begin
      rx_count <= rx_sat ? rx_count : rx_count + RX_W'(1);
      if (!id_ok) misroute_count <= mis_sat ? misroute_count : misroute_count + MIS_W'(1);
      else begin
        latency_sum <= sum_ext[LSUM_W] ? '1 : sum_ext[LSUM_W-1:0];
        latency_max <= (lat > latency_max) ? lat : latency_max;
      end
      overflow <= overflow | rx_sat | (!id_ok & mis_sat) | (id_ok & sum_ext[LSUM_W]);
    end
endmodule
